// File: rtl/switch_capture_pkg.sv
// switch_capture_pkg: shared widths and debounce FSM state encodings for switch_capture
package switch_capture_pkg;
  localparam int IO_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;
endpackage

// File: rtl/switch_capture_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus debounce FSM for the confirm button; press_accept fires in the cycle HELD is entered
module btn_debounce
  import switch_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic btn_level,
  output logic press_accept
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic btn;
  logic done;
  logic [CW-1:0] cnt, cnt_inc;
  btn_state_t state;
  assign btn = sync[1];
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
  assign done = cnt_inc == LAST;
  assign press_accept = (state == PRESS_WAIT) && btn && done;
  // two-stage synchronizer for the asynchronous button
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sync <= '0;
    else sync <= {sync[0], button};
  // debounce FSM: the cycle leaving IDLE/HELD counts as the first stable cycle, so D cycles of stable level are required
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      btn_level <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (btn) begin
            state <= PRESS_WAIT;
            cnt <= '0;
          end
        PRESS_WAIT:
          if (!btn) state <= IDLE;
          else if (done) begin
            state <= HELD;
            btn_level <= 1'b1;
          end else cnt <= cnt_inc;
        HELD:
          if (!btn) begin
            state <= RELEASE_WAIT;
            cnt <= '0;
          end
        RELEASE_WAIT:
          if (btn) state <= HELD;
          else if (done) begin
            state <= IDLE;
            btn_level <= 1'b0;
          end else cnt <= cnt_inc;
        default: begin
          state <= IDLE;
          btn_level <= 1'b0;
        end
      endcase
    end
endmodule

// File: rtl/switch_capture.sv
// switch_capture: captures synchronized switches on each debounced confirm press for CPU IO reads; SWITCH_OVERRUN_EN enables sw_overrun
module switch_capture
  import switch_capture_pkg::*;
#(
  parameter int SW_WIDTH = IO_WIDTH,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                confirm_button,
  input  logic                ior,
  input  logic                switchctrl,
  output logic [SW_WIDTH-1:0] ioread_data,
  output logic                sw_valid,
  output logic                btn_level,
  output logic                sw_overrun
);
  logic [SW_WIDTH-1:0] sw_s1, sw_s2;
  logic press_accept;
  logic consume;
  assign consume = ior && switchctrl;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock(clock),
    .reset_n(reset_n),
    .button(confirm_button),
    .btn_level(btn_level),
    .press_accept(press_accept)
  );
  // two-stage synchronizer for the asynchronous switch bus
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switches;
      sw_s2 <= sw_s1;
    end
  // capture register and valid flag; a capture beats a same-cycle consume
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ioread_data <= '0;
      sw_valid <= 1'b0;
    end else begin
      if (press_accept) ioread_data <= sw_s2;
      sw_valid <= press_accept ? 1'b1 : consume ? 1'b0 : sw_valid;
    end
`ifdef SWITCH_OVERRUN_EN
  // overrun flags a capture over an unread value; the next consume clears it
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sw_overrun <= 1'b0;
    else sw_overrun <= (press_accept && sw_valid && !consume) ? 1'b1 : consume ? 1'b0 : sw_overrun;
`else
  assign sw_overrun = 1'b0;
`endif
endmodule
